branch_unit: RTL

BRANCH_UNIT -- requirements
Module: branch_unit

---
 rtl/branch_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/branch_unit.sv
// ID-stage branch/jump resolution: hazard bubbles, taken decision, registered redirect and taken counter.
// Redirect and flush appear one cycle after a taken decision; the wrong-path ID slot in that cycle is ignored.
module branch_unit #(
  parameter int PC_SIZE  = 32,
  parameter int REG_ADDR = 5,
  parameter int CNT_SIZE = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic                id_is_beq,
  input  logic                id_is_bne,
  input  logic                id_is_jump,
  input  logic                cmp_eq,
  input  logic [PC_SIZE-1:0]  id_pc_plus4,
  input  logic [PC_SIZE-1:0]  id_offset,
  input  logic [PC_SIZE-1:0]  id_jtarget,
  input  logic [REG_ADDR-1:0] id_rs,
  input  logic [REG_ADDR-1:0] id_rt,
  input  logic                ex_reg_write,
  input  logic                ex_mem_read,
  input  logic [REG_ADDR-1:0] ex_rd,
  input  logic                mem_mem_read,
  input  logic [REG_ADDR-1:0] mem_rd,
  output logic                stall,
  output logic                redirect,
  output logic [PC_SIZE-1:0]  pc_target,
  output logic                if_id_flush,
  output logic [CNT_SIZE-1:0] taken_cnt
);

  typedef enum logic {S_RUN, S_STALL} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_count;
  logic [1:0]          w_count_nxt;
  logic                r_redirect;
  logic                r_flush;
  logic [PC_SIZE-1:0]  r_pc_target;
  logic [CNT_SIZE-1:0] r_taken_cnt;

  logic                w_branch;
  logic                w_jump;
  logic                w_taken;
  logic                w_ex_match;
  logic                w_mem_match;
  logic [1:0]          w_bubbles;
  logic                w_stall;
  logic                w_decide;
  logic [PC_SIZE-1:0]  w_off_sh;
  logic [PC_SIZE-1:0]  w_br_target;
  logic [PC_SIZE-1:0]  w_target;

  // Register zero is never a real producer, so it cannot create a hazard.
  function automatic logic hz_match(input logic [REG_ADDR-1:0] rd,
                                    input logic [REG_ADDR-1:0] rs,
                                    input logic [REG_ADDR-1:0] rt);
    return (rd != '0) && ((rd == rs) || (rd == rt));
  endfunction

  function automatic logic [CNT_SIZE-1:0] sat_inc(input logic [CNT_SIZE-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_branch    = id_valid & (id_is_beq | id_is_bne);
  assign w_jump      = id_valid & id_is_jump;
  assign w_taken     = (id_valid & id_is_beq & cmp_eq)
                     | (id_valid & id_is_bne & ~cmp_eq)
                     | w_jump;
  assign w_ex_match  = hz_match(ex_rd, id_rs, id_rt);
  assign w_mem_match = hz_match(mem_rd, id_rs, id_rt);

  // Offset is a word offset; the shift drops the top two bits and the add wraps.
  assign w_off_sh    = id_offset << 2;
  assign w_br_target = id_pc_plus4 + w_off_sh;
  assign w_target    = w_jump ? id_jtarget : w_br_target;

  always_comb begin
    w_bubbles = 2'd0;
    if (w_branch) begin
      if (ex_reg_write && ex_mem_read && w_ex_match) begin
        w_bubbles = 2'd2;
      end else if (ex_reg_write && w_ex_match) begin
        w_bubbles = 2'd1;
      end else if (mem_mem_read && w_mem_match) begin
        w_bubbles = 2'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_stall     = 1'b0;
    w_decide    = 1'b0;
    case (r_state)
      S_RUN: begin
        if (!r_redirect) begin
          if (w_bubbles != 2'd0) begin
            w_stall = 1'b1;
            if (w_bubbles == 2'd2) begin
              w_state_nxt = S_STALL;
              w_count_nxt = w_bubbles - 2'd1;
            end
          end else begin
            w_decide = w_taken;
          end
        end
      end
      S_STALL: begin
        w_stall     = 1'b1;
        w_count_nxt = (r_count != 2'd0) ? r_count - 2'd1 : 2'd0;
        if (w_count_nxt == 2'd0) begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
        w_count_nxt = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_count     <= 2'd0;
      r_redirect  <= 1'b0;
      r_flush     <= 1'b0;
      r_pc_target <= '0;
      r_taken_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_redirect <= w_decide;
      r_flush    <= w_decide;
      if (w_decide) begin
        r_pc_target <= w_target;
        r_taken_cnt <= sat_inc(r_taken_cnt);
      end
    end
  end

  // Stall is combinational from the hazard inputs, so it must be masked by reset.
  assign stall       = w_stall & rst_n;
  assign redirect    = r_redirect;
  assign if_id_flush = r_flush;
  assign pc_target   = r_pc_target;
  assign taken_cnt   = r_taken_cnt;

endmodule
